// File: rtl/i2c_target.sv
// I2C target with a 7-bit address. Write bytes appear on rx_data/rx_index with an
// rx_valid strobe; reads return the four bytes of tx_data captured at the address ACK.
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h1F,
   parameter int         NUM_BYTES   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i2c_scl,
   inout  wire         i2c_sda,
   input  logic [31:0] tx_data,
   output logic [7:0]  rx_data,
   output logic [1:0]  rx_index,
   output logic        rx_valid,
   output logic        addressed,
   output logic        busy
);

   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam logic [CW-1:0] MAX_COUNT = CW'(NUM_BYTES);
   localparam logic [1:0]    LAST_IDX  = 2'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
   } state_t;

   state_t          state;
   logic [1:0]      scl_sync, sda_sync;
   logic            scl_q, sda_q;
   logic            scl, sda;
   logic            scl_rise, scl_fall, start_det, stop_det;
   logic [3:0]      bit_cnt;
   logic [6:0]      shift;
   logic            rw;
   logic            ack_drive;
   logic [CW-1:0]   count;
   logic [1:0]      byte_idx;
   logic [31:0]     tx_latch;
   logic [7:0]      rd_byte;
   logic            sda_oe;

   assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, whatever order the statements appear in.
   always_ff @(posedge clock) begin
      if (reset) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], i2c_scl};
         sda_sync <= {sda_sync[0], i2c_sda};
         scl_q    <= scl_sync[1];
         sda_q    <= sda_sync[1];
      end
   end

   assign scl       = scl_sync[1];
   assign sda       = sda_sync[1];
   assign scl_rise  = scl & ~scl_q;
   assign scl_fall  = ~scl & scl_q;
   assign start_det = scl & scl_q & sda_q & ~sda;
   assign stop_det  = scl & scl_q & ~sda_q & sda;

   // NOTE: every case item assigns rd_byte, so this stays combinational with no latch.
   always_comb begin
      case (byte_idx)
         2'd0:    rd_byte = tx_latch[31:24];
         2'd1:    rd_byte = tx_latch[23:16];
         2'd2:    rd_byte = tx_latch[15:8];
         default: rd_byte = tx_latch[7:0];
      endcase
   end

   always_ff @(posedge clock) begin
      rx_valid <= 1'b0;
      if (reset) begin
         state     <= IDLE;
         sda_oe    <= 1'b0;
         rx_data   <= 8'h00;
         rx_index  <= 2'd0;
         addressed <= 1'b0;
         busy      <= 1'b0;
         bit_cnt   <= 4'd0;
         shift     <= 7'd0;
         rw        <= 1'b0;
         ack_drive <= 1'b0;
         count     <= '0;
         byte_idx  <= 2'd0;
         tx_latch  <= 32'd0;
      end else if (start_det) begin
         state     <= ADDR;
         bit_cnt   <= 4'd0;
         sda_oe    <= 1'b0;
         busy      <= 1'b1;
         addressed <= 1'b0;
         ack_drive <= 1'b0;
      end else if (stop_det) begin
         state     <= IDLE;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         addressed <= 1'b0;
      end else begin
         case (state)
            ADDR: if (scl_rise) begin
               shift   <= {shift[5:0], sda};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  rw    <= sda;
                  state <= (shift == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
               end
            end
            // The ACK slot spans two SCL falls: the first drives low, the second hands over.
            ADDR_ACK: if (scl_fall) begin
               if (!ack_drive) begin
                  ack_drive <= 1'b1;
                  sda_oe    <= 1'b1;
                  addressed <= 1'b1;
               end else begin
                  ack_drive <= 1'b0;
                  bit_cnt   <= 4'd0;
                  count     <= '0;
                  byte_idx  <= 2'd0;
                  if (rw) begin
                     tx_latch <= tx_data;
                     sda_oe   <= ~tx_data[31];
                     state    <= RD_BYTE;
                  end else begin
                     sda_oe <= 1'b0;
                     state  <= WR_BYTE;
                  end
               end
            end
            WR_BYTE: if (scl_rise) begin
               shift   <= {shift[5:0], sda};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  if (count < MAX_COUNT) begin
                     rx_data  <= {shift, sda};
                     rx_index <= 2'(count);
                     rx_valid <= 1'b1;
                     state    <= WR_ACK;
                  end else begin
                     state <= WAIT_STOP;
                  end
               end
            end
            WR_ACK: if (scl_fall) begin
               if (!ack_drive) begin
                  ack_drive <= 1'b1;
                  sda_oe    <= 1'b1;
                  count     <= count + CW'(1);
               end else begin
                  ack_drive <= 1'b0;
                  sda_oe    <= 1'b0;
                  bit_cnt   <= 4'd0;
                  state     <= WR_BYTE;
               end
            end
            RD_BYTE: begin
               if (scl_rise) begin
                  bit_cnt <= bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe <= 1'b0;
                     state  <= RD_ACK;
                  end else begin
                     sda_oe <= ~rd_byte[3'd7 - bit_cnt[2:0]];
                  end
               end
            end
            RD_ACK: if (scl_rise) begin
               if (sda) begin
                  state <= WAIT_STOP;
               end else begin
                  bit_cnt  <= 4'd0;
                  byte_idx <= (byte_idx == LAST_IDX) ? 2'd0 : byte_idx + 2'd1;
                  state    <= RD_BYTE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C controller driving i2c_target; expected ACKs, read bytes and
// rx strobes come from a transaction-level model of the bus protocol.
module tb_i2c_target;

   localparam logic [6:0] TADDR = 7'h1F;
   localparam int NB = 4;
   localparam int Q  = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        scl = 1'b1;
   logic        sda_low = 1'b0;
   logic [31:0] tx_data = 32'd0;
   logic [7:0]  rx_data;
   logic [1:0]  rx_index;
   logic        rx_valid, addressed, busy;
   wire         sda_bus;

   assign sda_bus = sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_target #(.TARGET_ADDR(TADDR), .NUM_BYTES(NB)) dut (
      .clock(clock), .reset(reset), .i2c_scl(scl), .i2c_sda(sda_bus),
      .tx_data(tx_data), .rx_data(rx_data), .rx_index(rx_index),
      .rx_valid(rx_valid), .addressed(addressed), .busy(busy)
   );

   always #5 clock = ~clock;

   int         vectors = 0;
   int         miscompares = 0;
   logic [9:0] exp_q[$];
   logic [9:0] mon_e;
   logic [7:0] wbuf [0:7];
   logic [7:0] rd_seen [0:7];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every strobe must match the next write byte the model says the target accepts.
   always @(negedge clock) begin
      if (!reset && rx_valid) begin
         if (exp_q.size() == 0) begin
            check("rx_valid_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rx_data", rx_data, mon_e[7:0]);
            check("rx_index", rx_index, mon_e[9:8]);
         end
      end
   end

   task automatic wait_q();
      repeat (Q) @(negedge clock);
   endtask

   task automatic bit_clk(input logic drive, output logic seen);
      sda_low = ~drive;
      wait_q();
      scl = 1'b1;
      wait_q();
      seen = sda_bus;
      wait_q();
      scl = 1'b0;
      wait_q();
   endtask

   task automatic i2c_start();
      sda_low = 1'b0;
      wait_q();
      scl = 1'b1;
      wait_q();
      sda_low = 1'b1;
      wait_q();
      scl = 1'b0;
      wait_q();
   endtask

   task automatic i2c_stop();
      sda_low = 1'b1;
      wait_q();
      scl = 1'b1;
      wait_q();
      sda_low = 1'b0;
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_clk(d[i], s);
         check("sda_data_bit", s, d[i]);
      end
      bit_clk(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_clk(1'b1, s);
         d[i] = s;
      end
      bit_clk(~ack, s);
   endtask

   task automatic txn_write(input logic [6:0] a, input int n);
      logic match, ack, ack_exp;
      match = (a == TADDR);
      i2c_start();
      check("busy_after_start", busy, 1'b1);
      write_byte({a, 1'b0}, ack);
      check("addr_ack_wr", ack, match);
      check("addressed_wr", addressed, match);
      for (int k = 0; k < n; k++) begin
         ack_exp = match && (k < NB);
         if (ack_exp) exp_q.push_back({2'(k), wbuf[k]});
         write_byte(wbuf[k], ack);
         check("data_ack", ack, ack_exp);
         if (!ack_exp) break;
      end
      i2c_stop();
      check("busy_after_stop", busy, 1'b0);
      check("addressed_after_stop", addressed, 1'b0);
      check("rx_pending", exp_q.size(), 0);
   endtask

   task automatic txn_read(input logic [6:0] a, input int n, input logic [31:0] word);
      logic match, ack;
      logic [7:0] d;
      logic [31:0] sh;
      match = (a == TADDR);
      tx_data = word;
      i2c_start();
      check("busy_after_start", busy, 1'b1);
      write_byte({a, 1'b1}, ack);
      check("addr_ack_rd", ack, match);
      check("addressed_rd", addressed, match);
      tx_data = $urandom();
      if (match) begin
         for (int k = 0; k < n; k++) begin
            read_byte(d, k < n - 1);
            rd_seen[k] = d;
            sh = word >> (8 * (3 - (k % 4)));
            check("rd_byte", d, sh[7:0]);
         end
      end
      check("sda_released_before_stop", sda_bus, 1'b1);
      i2c_stop();
      check("busy_after_stop", busy, 1'b0);
      check("rx_pending", exp_q.size(), 0);
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic       ack, s;
      logic [7:0] ab;
      logic [6:0] ra;
      int         rn;

      repeat (4) @(negedge clock);
      check("reset_sda", sda_bus, 1'b1);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_index", rx_index, 2'd0);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_addressed", addressed, 1'b0);
      check("reset_busy", busy, 1'b0);
      reset = 1'b0;
      wait_q();

      // Simple write of one byte.
      wbuf[0] = 8'h20;
      txn_write(TADDR, 1);
      check("wr_rx_data_lit", rx_data, 8'h20);
      check("wr_rx_index_lit", rx_index, 2'd0);

      // Read four bytes, NACK on the last.
      txn_read(TADDR, 4, 32'hA55A0FF0);
      check("rd0_lit", rd_seen[0], 8'hA5);
      check("rd1_lit", rd_seen[1], 8'h5A);
      check("rd2_lit", rd_seen[2], 8'h0F);
      check("rd3_lit", rd_seen[3], 8'hF0);

      // Address 0x40 on the wire is someone else.
      wbuf[0] = 8'h77;
      txn_write(7'h20, 1);

      // Five bytes into a four-byte target.
      for (int k = 0; k < 5; k++) wbuf[k] = 8'(k + 1);
      txn_write(TADDR, 5);
      check("ovf_rx_data_lit", rx_data, 8'h04);
      check("ovf_rx_index_lit", rx_index, 2'd3);

      // Repeated START in the middle of a write byte, then a read.
      i2c_start();
      write_byte({TADDR, 1'b0}, ack);
      check("rs_addr_ack", ack, 1'b1);
      for (int i = 0; i < 4; i++) bit_clk(1'(i % 2), s);
      txn_read(TADDR, 4, 32'h1234_5678);
      check("rs_rx_data_kept", rx_data, 8'h04);
      check("rs_rx_index_kept", rx_index, 2'd3);

      // Reset while the target holds the address ACK low.
      i2c_start();
      ab = {TADDR, 1'b0};
      for (int i = 7; i >= 0; i--) bit_clk(ab[i], s);
      sda_low = 1'b0;
      wait_q();
      scl = 1'b1;
      wait_q();
      check("ack_low_before_reset", sda_bus, 1'b0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("sda_released_1clk", sda_bus, 1'b1);
      @(negedge clock);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_index", rx_index, 2'd0);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_addressed", addressed, 1'b0);
      check("rst_busy", busy, 1'b0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      wait_q();
      scl = 1'b0;
      wait_q();
      i2c_stop();
      check("busy_after_reset_stop", busy, 1'b0);
      wbuf[0] = 8'h5C;
      wbuf[1] = 8'hC5;
      txn_write(TADDR, 2);
      check("post_reset_rx_data", rx_data, 8'hC5);
      check("post_reset_rx_index", rx_index, 2'd1);

      // Randomized mix of reads and writes, mostly to this target.
      for (int t = 0; t < 14; t++) begin
         ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : TADDR;
         if ($urandom_range(0, 1) == 1) begin
            rn = $urandom_range(1, 6);
            for (int k = 0; k < rn; k++) wbuf[k] = 8'($urandom());
            txn_write(ra, rn);
         end else begin
            txn_read(ra, $urandom_range(1, 6), $urandom());
         end
      end

      wait_q();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
